cell_writeback: RTL

- Sits directly downstream of the position-update / cell-index stage.
- Consumes each particle's {cell index, wrapped position} pair and scatters it into a banked cell memory: region = cell index, slot = per-cell fill counter.
- Owns per-cell occupancy counters for one timestep and clears them at the step boundary, so the next force phase reads densely packed cells.

---
 rtl/cell_wb_pkg.sv | 35 +++
 rtl/cell_wb_fifo.sv | 73 +++++++
 rtl/cell_writeback.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cell_wb_pkg.sv
// rtl/cell_wb_pkg.sv - shared constants, state enum and field offsets for the cell writeback slice
package cell_wb_pkg;

  localparam int NUM_CELLS  = 27;
  localparam int CELL_CAP   = 64;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 11;
  localparam int CNT_W      = $clog2(CELL_CAP + 1);
  localparam int CIDX_W     = 32;

  // Position word layout: three fp32 lanes, x in the low lane.
  localparam int POS_W     = 96;
  localparam int POS_X_LSB = 0;
  localparam int POS_Y_LSB = 32;
  localparam int POS_Z_LSB = 64;

  // Null flags ride one bit above the payload in both input words.
  localparam int CIDX_NULL_BIT = 32;
  localparam int POS_NULL_BIT  = 96;

  // FIFO entry is {pos with flag, cidx with flag}.
  localparam int ENTRY_W = (CIDX_W + 1) + (POS_W + 1);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    DRAIN  = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  // Either copy of the null flag marks the entry as carrying no particle.
  function automatic logic is_null(input logic [CIDX_W:0] cidx, input logic [POS_W:0] pos);
    return cidx[CIDX_NULL_BIT] | pos[POS_NULL_BIT];
  endfunction

endpackage

// File: rtl/cell_wb_fifo.sv
// rtl/cell_wb_fifo.sv - synchronous FIFO with a registered first-word output stage
module cell_wb_fifo #(
  parameter int WIDTH = 130,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             push_ok;
  logic             load;

  // Full/empty look at the storage array; the output register is one extra slot.
  assign full    = (count == (PW + 1)'(DEPTH));
  assign push_ok = push && !full;
  assign load    = (count != '0) && (!dout_valid || pop);
  assign empty   = (count == '0) && !dout_valid;

  // Storage array write port; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, load})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Head-of-queue register: refills whenever it is empty or being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load) begin
      dout       <= mem[rd_ptr];
      dout_valid <= 1'b1;
    end else if (pop) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cell_writeback.sv
// rtl/cell_writeback.sv - scatters particles into banked cell memory; optional CELL_WB_COUNT_PORT_EN adds a count readback port
module cell_writeback #(
  parameter int NUM_CELLS  = cell_wb_pkg::NUM_CELLS,
  parameter int CELL_CAP   = cell_wb_pkg::CELL_CAP,
  parameter int FIFO_DEPTH = cell_wb_pkg::FIFO_DEPTH,
  parameter int ADDR_W     = cell_wb_pkg::ADDR_W,
  parameter int CNT_W      = $clog2(CELL_CAP + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32:0]       in_cidx,
  input  logic [96:0]       in_pos,
  input  logic              step_end,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [95:0]       mem_wdata,
  output logic              step_done,
  output logic              ovf_err,
  output logic              idx_err
`ifdef CELL_WB_COUNT_PORT_EN
  ,
  input  logic [4:0]        cnt_rd_idx,
  output logic [CNT_W-1:0]  cnt_rd_data
`endif
);

  import cell_wb_pkg::*;

  localparam int                CI_W        = $clog2(NUM_CELLS);
  localparam logic [CIDX_W-1:0] NUM_CELLS_U = CIDX_W'(NUM_CELLS);
  localparam logic [CNT_W-1:0]  CAP_CNT     = CNT_W'(CELL_CAP);

  state_t             state;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_valid;
  logic               push;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;

  logic [CIDX_W:0]    pop_cidx;
  logic [POS_W:0]     pop_pos;
  logic [CI_W-1:0]    pop_cell;
  logic [CNT_W-1:0]   pop_cnt;
  logic               pop_null;
  logic               pop_in_range;
  logic               pop_cell_full;
  logic               do_write;
  logic [ADDR_W-1:0]  pop_addr;
  logic               mem_we_r;

  logic [CNT_W-1:0]   cnt [NUM_CELLS];

  assign in_ready = (state == ACCEPT) && !fifo_full;
  assign push     = in_valid && in_ready;
  assign fifo_din = {in_pos, in_cidx};

  cell_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .din        (fifo_din),
    .full       (fifo_full),
    .pop        (fifo_valid),
    .dout       (fifo_dout),
    .dout_valid (fifo_valid),
    .empty      (fifo_empty)
  );

  // The head entry is consumed every cycle it is valid; classification is purely combinational.
  assign pop_cidx      = fifo_dout[CIDX_W:0];
  assign pop_pos       = fifo_dout[ENTRY_W-1:CIDX_W+1];
  assign pop_cell      = pop_cidx[CI_W-1:0];
  assign pop_null      = is_null(pop_cidx, pop_pos);
  assign pop_in_range  = (pop_cidx[CIDX_W-1:0] < NUM_CELLS_U);
  assign pop_cnt       = cnt[pop_cell];
  assign pop_cell_full = (pop_cnt == CAP_CNT);
  assign do_write      = fifo_valid && !pop_null && pop_in_range && !pop_cell_full;
  // Constant multiply by CELL_CAP; a power-of-two capacity folds to a shift.
  assign pop_addr      = ADDR_W'(pop_cell) * ADDR_W'(CELL_CAP) + ADDR_W'(pop_cnt);

  // A registered write can never leave the block once reset is being sampled.
  assign mem_we = mem_we_r && !rst;

  // Output write register and sticky drop flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_r  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ovf_err   <= 1'b0;
      idx_err   <= 1'b0;
    end else begin
      mem_we_r <= do_write;
      if (do_write) begin
        mem_addr  <= pop_addr;
        mem_wdata <= {pop_pos[POS_Z_LSB +: 32], pop_pos[POS_Y_LSB +: 32], pop_pos[POS_X_LSB +: 32]};
      end
      if (fifo_valid && !pop_null && !pop_in_range) begin
        idx_err <= 1'b1;
      end
      if (fifo_valid && !pop_null && pop_in_range && pop_cell_full) begin
        ovf_err <= 1'b1;
      end
    end
  end

  // Per-cell fill counters: bumped in the same edge as the write so the next pop sees the new slot.
  always_ff @(posedge clk) begin
    if (rst || state == CLEAR) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        cnt[i] <= '0;
      end
    end else if (do_write) begin
      cnt[pop_cell] <= pop_cnt + CNT_W'(1);
    end
  end

  // Step sequencing: stop accepting, wait for the pipe to empty, then clear counters for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCEPT;
      step_done <= 1'b0;
    end else begin
      step_done <= 1'b0;
      case (state)
        ACCEPT: begin
          if (step_end) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && !mem_we_r) begin
            state     <= CLEAR;
            step_done <= 1'b1;
          end
        end
        CLEAR: begin
          state <= ACCEPT;
        end
        default: begin
          state <= ACCEPT;
        end
      endcase
    end
  end

`ifdef CELL_WB_COUNT_PORT_EN
  // Registered count readback; during CLEAR it still sees the pre-clear values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_rd_data <= '0;
    end else if (CIDX_W'(cnt_rd_idx) < NUM_CELLS_U) begin
      cnt_rd_data <= cnt[cnt_rd_idx];
    end else begin
      cnt_rd_data <= '0;
    end
  end
`endif

endmodule
